// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the voice allocator
package synth_pkg;

    localparam int MAX_IDX_W = 8;
    localparam int NOTE_NONE = -1;

    typedef enum logic [1:0] {FREE, RELEASING, GATED} voice_cls_e;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_e;

    // idx is sized for the widest supported note index; narrower builds zero-extend
    typedef struct packed {
        logic                 on;
        logic [MAX_IDX_W-1:0] idx;
    } note_evt_t;

    function automatic voice_cls_e classify(input logic gate, input logic env_idle);
        if (gate)
            return GATED;
        else if (env_idle)
            return FREE;
        else
            return RELEASING;
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// rtl/voice_age_tracker.sv - per-voice saturating age counters
module voice_age_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             assign_en_i,
    input  logic [VW-1:0]                    assign_v_i,
    output logic [NUM_VOICES-1:0][AGE_W-1:0] age_o
);

    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;

    // an assignment makes the target youngest and ages everyone else
    always_comb begin
        age_d = age_q;
        if (assign_en_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VW'(v) == assign_v_i)
                    age_d[v] = '0;
                else if (age_q[v] != '1)
                    age_d[v] = age_q[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            age_q <= '0;
        else
            age_q <= age_d;
    end

    assign age_o = age_q;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler; VOICE_STEAL_EN enables stealing the oldest gated voice
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = 6,
    parameter int AGE_W      = 8
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        noteTrig,
    input  logic                        noteOff,
    input  logic [31:0]                 noteIdx,
    input  logic [NUM_VOICES-1:0]       envIdle,
    output logic [NUM_VOICES-1:0]       voiceGate,
    output logic [NUM_VOICES-1:0]       voiceTrig,
    output logic [NUM_VOICES*IDX_W-1:0] voiceNote,
    output logic                        busy,
    output logic [7:0]                  dropCount
);

    localparam int VW = $clog2(NUM_VOICES);

    alloc_state_e                     state_q, state_d;
    note_evt_t                        pend_q, pend_d, work_q, work_d, evt;
    logic                             pend_vld_q, pend_vld_d, evt_valid;
    logic [VW-1:0]                    scan_q, scan_d;
    logic                             m_fnd_q, m_fnd_d, f_fnd_q, f_fnd_d, r_fnd_q, r_fnd_d;
    logic [VW-1:0]                    m_v_q, m_v_d, f_v_q, f_v_d, r_v_q, r_v_d;
    logic [AGE_W-1:0]                 r_age_q, r_age_d;
`ifdef VOICE_STEAL_EN
    logic                             g_fnd_q, g_fnd_d;
    logic [VW-1:0]                    g_v_q, g_v_d;
    logic [AGE_W-1:0]                 g_age_q, g_age_d;
`endif
    logic [NUM_VOICES-1:0]            off_mask_q, off_mask_d;
    logic [NUM_VOICES-1:0]            gate_q, gate_d, trig_q, trig_d;
    logic [NUM_VOICES-1:0][IDX_W-1:0] note_q, note_d;
    logic [7:0]                       drop_q, drop_d;
    logic [8:0]                       drop_sum;
    logic [1:0]                       drops;
    logic                             start_scan, asg_en, tgt_fnd, hit;
    logic [VW-1:0]                    asg_v, tgt;
    logic [NUM_VOICES-1:0][AGE_W-1:0] ages;
    voice_cls_e                       cur_cls;
    logic [AGE_W-1:0]                 cur_age;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .VW         (VW)
    ) u_age (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .assign_en_i (asg_en),
        .assign_v_i  (asg_v),
        .age_o       (ages)
    );

    assign evt_valid = (noteTrig | noteOff) && ($signed(noteIdx) > NOTE_NONE)
                       && (noteIdx[31:IDX_W] == '0);
    assign evt.on    = noteTrig;
    assign evt.idx   = MAX_IDX_W'(noteIdx[IDX_W-1:0]);

    assign cur_cls = classify(gate_q[scan_q], envIdle[scan_q]);
    assign cur_age = ages[scan_q];
    assign hit     = (work_q.idx == MAX_IDX_W'(note_q[scan_q]));

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        work_d     = work_q;
        scan_d     = scan_q;
        m_fnd_d    = m_fnd_q;
        m_v_d      = m_v_q;
        f_fnd_d    = f_fnd_q;
        f_v_d      = f_v_q;
        r_fnd_d    = r_fnd_q;
        r_v_d      = r_v_q;
        r_age_d    = r_age_q;
`ifdef VOICE_STEAL_EN
        g_fnd_d    = g_fnd_q;
        g_v_d      = g_v_q;
        g_age_d    = g_age_q;
`endif
        off_mask_d = off_mask_q;
        gate_d     = gate_q;
        trig_d     = '0;
        note_d     = note_q;
        drops      = 2'd0;
        start_scan = 1'b0;
        asg_en     = 1'b0;
        asg_v      = '0;
        tgt        = '0;
        tgt_fnd    = 1'b0;

        // a single pending slot absorbs events that arrive while the FSM is working
        if (evt_valid) begin
            if (state_q == IDLE && !pend_vld_q) begin
                work_d     = evt;
                start_scan = 1'b1;
            end else if (!pend_vld_q) begin
                pend_d     = evt;
                pend_vld_d = 1'b1;
            end else begin
                drops = drops + 2'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    work_d     = pend_q;
                    pend_vld_d = 1'b0;
                    start_scan = 1'b1;
                end
            end
            SCAN: begin
                if (cur_cls != FREE && hit && !m_fnd_q) begin
                    m_fnd_d = 1'b1;
                    m_v_d   = scan_q;
                end
                if (cur_cls == FREE && !f_fnd_q) begin
                    f_fnd_d = 1'b1;
                    f_v_d   = scan_q;
                end
                if (cur_cls == RELEASING && (!r_fnd_q || cur_age > r_age_q)) begin
                    r_fnd_d = 1'b1;
                    r_v_d   = scan_q;
                    r_age_d = cur_age;
                end
`ifdef VOICE_STEAL_EN
                if (cur_cls == GATED && (!g_fnd_q || cur_age > g_age_q)) begin
                    g_fnd_d = 1'b1;
                    g_v_d   = scan_q;
                    g_age_d = cur_age;
                end
`endif
                if (cur_cls == GATED && hit)
                    off_mask_d[scan_q] = 1'b1;
                scan_d = scan_q + 1'b1;
                if (scan_q == VW'(NUM_VOICES - 1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                if (work_q.on) begin
                    tgt_fnd = 1'b1;
                    if (m_fnd_q)
                        tgt = m_v_q;
                    else if (f_fnd_q)
                        tgt = f_v_q;
                    else if (r_fnd_q)
                        tgt = r_v_q;
`ifdef VOICE_STEAL_EN
                    else if (g_fnd_q)
                        tgt = g_v_q;
`endif
                    else
                        tgt_fnd = 1'b0;
                    if (tgt_fnd) begin
                        gate_d[tgt] = 1'b1;
                        trig_d[tgt] = 1'b1;
                        note_d[tgt] = work_q.idx[IDX_W-1:0];
                        asg_en      = 1'b1;
                        asg_v       = tgt;
                    end else begin
                        drops = drops + 2'd1;
                    end
                end else begin
                    gate_d = gate_q & ~off_mask_q;
                end
                if (pend_vld_q) begin
                    work_d     = pend_q;
                    pend_vld_d = 1'b0;
                    start_scan = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_scan) begin
            state_d    = SCAN;
            scan_d     = '0;
            m_fnd_d    = 1'b0;
            f_fnd_d    = 1'b0;
            r_fnd_d    = 1'b0;
            r_age_d    = '0;
`ifdef VOICE_STEAL_EN
            g_fnd_d    = 1'b0;
            g_age_d    = '0;
`endif
            off_mask_d = '0;
        end

        drop_sum = {1'b0, drop_q} + 9'(drops);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            work_q     <= '0;
            scan_q     <= '0;
            m_fnd_q    <= 1'b0;
            m_v_q      <= '0;
            f_fnd_q    <= 1'b0;
            f_v_q      <= '0;
            r_fnd_q    <= 1'b0;
            r_v_q      <= '0;
            r_age_q    <= '0;
`ifdef VOICE_STEAL_EN
            g_fnd_q    <= 1'b0;
            g_v_q      <= '0;
            g_age_q    <= '0;
`endif
            off_mask_q <= '0;
            gate_q     <= '0;
            trig_q     <= '0;
            note_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            work_q     <= work_d;
            scan_q     <= scan_d;
            m_fnd_q    <= m_fnd_d;
            m_v_q      <= m_v_d;
            f_fnd_q    <= f_fnd_d;
            f_v_q      <= f_v_d;
            r_fnd_q    <= r_fnd_d;
            r_v_q      <= r_v_d;
            r_age_q    <= r_age_d;
`ifdef VOICE_STEAL_EN
            g_fnd_q    <= g_fnd_d;
            g_v_q      <= g_v_d;
            g_age_q    <= g_age_d;
`endif
            off_mask_q <= off_mask_d;
            gate_q     <= gate_d;
            trig_q     <= trig_d;
            note_q     <= note_d;
            drop_q     <= drop_d;
        end
    end

    assign voiceGate = gate_q;
    assign voiceTrig = trig_q;
    assign voiceNote = note_q;
    assign busy      = (state_q != IDLE) | pend_vld_q;
    assign dropCount = drop_q;

endmodule
